// File: rtl/fetch_bundle_unit.sv
// fetch_bundle_unit: N-wide fetch front end with a byte-wide big-endian instruction memory and a valid/ready bundle output (optional FETCH_HALT_ON_ZERO_EN: an all-zero bundle halts fetch)
module fetch_bundle_unit #(
    parameter int FETCH_WIDTH = 2,
    parameter int IMEM_BYTES  = 128,
    parameter int PC_W        = $clog2(IMEM_BYTES),
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        imem_we,
    input  logic [PC_W-1:0]             imem_waddr,
    input  logic [7:0]                  imem_wdata,
    input  logic                        start,
    input  logic                        redirect_valid,
    input  logic [PC_W-1:0]             redirect_pc,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [32*FETCH_WIDTH-1:0]   out_instr,
    output logic [PC_W*FETCH_WIDTH-1:0] out_pc,
    output logic [FETCH_WIDTH-1:0]      out_slot_valid,
    output logic [CNT_W-1:0]            out_cycle,
    output logic [CNT_W-1:0]            cycle_count,
    output logic [CNT_W-1:0]            instr_count,
    output logic                        done
);
    // one spare PC bit so a bundle ending exactly at the top of memory does not wrap
    localparam int AW = PC_W + 1;
    localparam logic [AW-1:0] STEP = AW'(4 * FETCH_WIDTH);
    localparam logic [AW:0] LIMIT = (AW + 1)'(IMEM_BYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_d;
    logic [7:0] mem [IMEM_BYTES];
    logic [AW-1:0] pc, pc_next, addr;
    logic [32*FETCH_WIDTH-1:0] fetch_instr;
    logic [PC_W*FETCH_WIDTH-1:0] fetch_pc;
    logic [FETCH_WIDTH-1:0] fetch_mask;
    logic [3:0] pop;
    logic [CNT_W:0] instr_sum;
    logic go, redir, accept, load, halt, zero_stop;

    // redirect in IDLE only takes effect together with start
    assign go = state == RUN || (state == IDLE && start);
    assign redir = redirect_valid && (state != IDLE || start);
    assign accept = out_valid && out_ready;
    assign load = go && !redir && (!out_valid || out_ready);
    assign pc_next = pc + STEP;
    assign halt = {1'b0, pc_next} + {1'b0, STEP} > LIMIT;
    assign instr_sum = {1'b0, instr_count} + (CNT_W + 1)'(pop);

`ifdef FETCH_HALT_ON_ZERO_EN
    assign zero_stop = ~|fetch_mask;
`else
    assign zero_stop = 1'b0;
`endif

    // program load port; reads are combinational so a same-cycle write is not seen
    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
    end

    // gather FETCH_WIDTH big-endian words from pc; bytes past the end read as zero
    always_comb begin
        addr = '0;
        fetch_instr = '0;
        fetch_pc = '0;
        fetch_mask = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            for (int b = 0; b < 4; b++) begin
                addr = pc + AW'(4 * k + b);
                fetch_instr[32*k+31-8*b -: 8] = addr < AW'(IMEM_BYTES) ? mem[addr[PC_W-1:0]] : 8'h00;
            end
            fetch_pc[PC_W*k +: PC_W] = pc[PC_W-1:0] + PC_W'(4 * k);
            fetch_mask[k] = |fetch_instr[32*k +: 32];
        end
    end

    // number of live slots in the bundle currently offered to decode
    always_comb begin
        pop = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) pop = pop + 4'(out_slot_valid[k]);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    // next state: redirect beats halt, halt beats staying in RUN
    always_comb begin
        state_d = redir ? RUN : (load && (halt || zero_stop)) ? DONE : go ? RUN : state;
    end

    // state-derived outputs
    always_comb begin
        done = state == DONE;
    end

    // bundle register, fetch PC and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc <= '0;
            out_slot_valid <= '0;
            out_cycle <= '0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state == RUN) cycle_count <= cycle_count + CNT_W'(cycle_count != '1);
            if (accept) instr_count <= instr_sum[CNT_W] ? '1 : instr_sum[CNT_W-1:0];
            if (redir) begin
                pc <= {1'b0, redirect_pc & ~PC_W'(3)};
                out_valid <= 1'b0;
            end else if (load) begin
                pc <= pc_next;
                out_valid <= !zero_stop;
                out_instr <= fetch_instr;
                out_pc <= fetch_pc;
                out_slot_valid <= fetch_mask;
                out_cycle <= cycle_count;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_bundle_unit.sv
// tb_fetch_bundle_unit: directed checks of a 2-wide/128-byte and a 4-wide/64-byte fetch unit
module tb_fetch_bundle_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic imem_we = 1'b0;
    logic [6:0] imem_waddr = '0;
    logic [7:0] imem_wdata = '0;
    logic start = 1'b0;
    logic redirect_valid = 1'b0;
    logic [6:0] redirect_pc = '0;
    logic out_ready = 1'b0;
    logic out_valid;
    logic [63:0] out_instr;
    logic [13:0] out_pc;
    logic [1:0] out_slot_valid;
    logic [31:0] out_cycle, cycle_count, instr_count;
    logic done;

    logic b_rst_n = 1'b0;
    logic b_we = 1'b0;
    logic [5:0] b_waddr = '0;
    logic [7:0] b_wdata = '0;
    logic b_start = 1'b0;
    logic b_ready = 1'b0;
    logic b_valid;
    logic [127:0] b_instr;
    logic [23:0] b_pc;
    logic [3:0] b_slot;
    logic [31:0] b_out_cycle, b_cycle, b_icount;
    logic b_done;

    logic [31:0] prog [32];
    logic [31:0] prog_b [16];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_bundle_unit #(.FETCH_WIDTH(2), .IMEM_BYTES(128), .PC_W(7), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .start(start), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_ready(out_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_slot_valid(out_slot_valid),
        .out_cycle(out_cycle), .cycle_count(cycle_count), .instr_count(instr_count), .done(done)
    );

    fetch_bundle_unit #(.FETCH_WIDTH(4), .IMEM_BYTES(64), .PC_W(6), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .imem_we(b_we), .imem_waddr(b_waddr), .imem_wdata(b_wdata),
        .start(b_start), .redirect_valid(1'b0), .redirect_pc(6'd0), .out_ready(b_ready),
        .out_valid(b_valid), .out_instr(b_instr), .out_pc(b_pc), .out_slot_valid(b_slot),
        .out_cycle(b_out_cycle), .cycle_count(b_cycle), .instr_count(b_icount), .done(b_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic load_a();
        logic [31:0] w;
        for (int i = 0; i < 128; i++) begin
            w = prog[i / 4];
            imem_we = 1'b1;
            imem_waddr = 7'(i);
            imem_wdata = w[8*(3 - i % 4) +: 8];
            step();
        end
        imem_we = 1'b0;
    endtask

    task automatic load_b();
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = prog_b[i / 4];
            b_we = 1'b1;
            b_waddr = 6'(i);
            b_wdata = w[8*(3 - i % 4) +: 8];
            step();
        end
        b_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycles got=%0d exp=0", cycle_count); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_icount got=%0d exp=0", instr_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        rst_n = 1'b1;
        repeat (2) step();
        checks++; if (out_valid !== 1'b0 || cycle_count !== 32'd0) begin errors++; $display("FAIL idle_hold got valid=%0b cyc=%0d exp 0/0", out_valid, cycle_count); end
    endtask

    task automatic test_fetch_2wide();
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
        prog[0] = 32'h00500093;
        prog[1] = 32'h00A00113;
        reset_a();
        load_a();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got=%0b exp=1", out_valid); end
        checks++; if (out_instr !== 64'h00A00113_00500093) begin errors++; $display("FAIL fetch_instr got=%h exp=00a0011300500093", out_instr); end
        checks++; if (out_pc !== {7'd4, 7'd0}) begin errors++; $display("FAIL fetch_pc got=%h exp=%h", out_pc, {7'd4, 7'd0}); end
        checks++; if (out_slot_valid !== 2'b11) begin errors++; $display("FAIL fetch_slots got=%b exp=11", out_slot_valid); end
        checks++; if (out_cycle !== 32'd0) begin errors++; $display("FAIL fetch_outcycle got=%0d exp=0", out_cycle); end
        step();
        checks++; if (instr_count !== 32'd2) begin errors++; $display("FAIL fetch_icount got=%0d exp=2", instr_count); end
        checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL fetch_cycles got=%0d exp=1", cycle_count); end
        checks++; if (out_pc !== {7'd12, 7'd8}) begin errors++; $display("FAIL fetch_pc2 got=%h exp=%h", out_pc, {7'd12, 7'd8}); end
    endtask

    task automatic test_zero_halt();
        int n;
        for (int i = 0; i < 32; i++) prog[i] = i < 6 ? 32'h00100013 + 32'(i << 20) : 32'h0;
        reset_a();
        load_a();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        checks++; if (instr_count !== 32'd6) begin errors++; $display("FAIL zero_icount got=%0d exp=6", instr_count); end
`ifdef FETCH_HALT_ON_ZERO_EN
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_halt got done=%0b valid=%0b exp 1/0", done, out_valid); end
        repeat (3) step();
        checks++; if (instr_count !== 32'd6 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_after got icount=%0d valid=%0b exp 6/0", instr_count, out_valid); end
`else
        checks++; if (out_valid !== 1'b1 || out_slot_valid !== 2'b00 || done !== 1'b0) begin errors++; $display("FAIL zero_present got valid=%0b slots=%b done=%0b exp 1/00/0", out_valid, out_slot_valid, done); end
        n = 0;
        while (!done && n < 40) begin step(); n++; end
        checks++; if (done !== 1'b1 || out_pc !== {7'd124, 7'd120}) begin errors++; $display("FAIL zero_end got done=%0b pc=%h exp 1/%h", done, out_pc, {7'd124, 7'd120}); end
        step();
        checks++; if (instr_count !== 32'd6 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_final got icount=%0d valid=%0b exp 6/0", instr_count, out_valid); end
`endif
    endtask

    task automatic test_backpressure_halt();
        int n;
        for (int i = 0; i < 32; i++) prog[i] = 32'h10000000 + 32'(i);
        reset_a();
        load_a();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_pc !== {7'd4, 7'd0} || out_instr !== {prog[1], prog[0]}) begin errors++; $display("FAIL stall_hold got valid=%0b pc=%h instr=%h", out_valid, out_pc, out_instr); end
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_pc !== {7'd12, 7'd8} || out_instr !== {prog[3], prog[2]}) begin errors++; $display("FAIL release_next got pc=%h instr=%h exp pc=%h", out_pc, out_instr, {7'd12, 7'd8}); end
        checks++; if (out_cycle !== 32'd4 || cycle_count !== 32'd5) begin errors++; $display("FAIL release_cycles got out=%0d cyc=%0d exp 4/5", out_cycle, cycle_count); end
        checks++; if (instr_count !== 32'd2) begin errors++; $display("FAIL release_icount got=%0d exp=2", instr_count); end
        n = 0;
        while (!done && n < 40) begin step(); n++; end
        checks++; if (done !== 1'b1 || out_valid !== 1'b1 || out_pc !== {7'd124, 7'd120}) begin errors++; $display("FAIL halt_last got done=%0b valid=%0b pc=%h", done, out_valid, out_pc); end
        repeat (2) step();
        checks++; if (instr_count !== 32'd32 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_drain got icount=%0d valid=%0b exp 32/0", instr_count, out_valid); end
        checks++; if (cycle_count !== 32'd19) begin errors++; $display("FAIL halt_cycles got=%0d exp=19", cycle_count); end
        redirect_valid = 1'b1;
        redirect_pc = 7'd124;
        step();
        redirect_valid = 1'b0;
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL done_redirect got done=%0b valid=%0b exp 0/0", done, out_valid); end
        step();
        checks++; if (out_instr !== {32'h0, prog[31]} || out_slot_valid !== 2'b01) begin errors++; $display("FAIL past_end got instr=%h slots=%b exp slots=01", out_instr, out_slot_valid); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL past_end_done got=%0b exp=1", done); end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 32; i++) prog[i] = 32'h30000000 + 32'(i);
        reset_a();
        load_a();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        out_ready = 1'b0;
        step();
        checks++; if (out_pc !== {7'd20, 7'd16} || instr_count !== 32'd4) begin errors++; $display("FAIL redir_stall got pc=%h icount=%0d exp %h/4", out_pc, instr_count, {7'd20, 7'd16}); end
        redirect_valid = 1'b1;
        redirect_pc = 7'h03;
        step();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || instr_count !== 32'd4) begin errors++; $display("FAIL redir_drop got valid=%0b icount=%0d exp 0/4", out_valid, instr_count); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== {7'd4, 7'd0} || out_instr !== {prog[1], prog[0]}) begin errors++; $display("FAIL redir_first got valid=%0b pc=%h instr=%h", out_valid, out_pc, out_instr); end
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 7'd40;
        step();
        redirect_valid = 1'b0;
        checks++; if (instr_count !== 32'd6 || out_valid !== 1'b0) begin errors++; $display("FAIL redir_accept got icount=%0d valid=%0b exp 6/0", instr_count, out_valid); end
        step();
        checks++; if (out_pc !== {7'd44, 7'd40} || out_instr !== {prog[11], prog[10]}) begin errors++; $display("FAIL redir_target got pc=%h instr=%h", out_pc, out_instr); end
    endtask

    task automatic test_wide4();
        for (int i = 0; i < 16; i++) prog_b[i] = 32'h20000000 + 32'(i);
        b_rst_n = 1'b1;
        load_b();
        b_ready = 1'b1;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        checks++; if (b_pc !== {6'd12, 6'd8, 6'd4, 6'd0} || b_slot !== 4'hF) begin errors++; $display("FAIL wide_first got pc=%h slots=%b", b_pc, b_slot); end
        repeat (3) step();
        checks++; if (b_done !== 1'b1 || b_pc !== {6'd60, 6'd56, 6'd52, 6'd48} || b_instr[127:96] !== prog_b[15]) begin errors++; $display("FAIL wide_last got done=%0b pc=%h top=%h", b_done, b_pc, b_instr[127:96]); end
        step();
        checks++; if (b_icount !== 32'd16 || b_valid !== 1'b0) begin errors++; $display("FAIL wide_count got icount=%0d valid=%0b exp 16/0", b_icount, b_valid); end
        b_rst_n = 1'b0;
        step();
        b_rst_n = 1'b1;
        b_ready = 1'b0;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        step();
        checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL wide_stall got valid=%0b exp=1", b_valid); end
        #2 b_rst_n = 1'b0;
        #1;
        checks++; if (b_valid !== 1'b0 || b_done !== 1'b0 || b_cycle !== 32'd0) begin errors++; $display("FAIL async_reset got valid=%0b done=%0b cyc=%0d exp 0/0/0", b_valid, b_done, b_cycle); end
        step();
        b_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch_2wide();
        test_zero_halt();
        test_backpressure_halt();
        test_redirect();
        test_wide4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
